// File: rtl/psg_mix_pkg.sv
// Shared types and constants for the PSG stereo mixer.
package psg_mix_pkg;

  typedef enum logic [1:0] {
    MONO = 2'b00,
    ABC  = 2'b01,
    ACB  = 2'b10
  } stereo_mode_e;

  localparam int unsigned CENTER_OFFSET = 24576;
  localparam int unsigned DC_SHIFT      = 8;
  localparam int unsigned MIX_W         = 10;

endpackage

// File: rtl/psg_dc_block.sv
// Single-channel one-pole DC blocker; state advances only on EN.
module psg_dc_block
  import psg_mix_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic signed [16:0] X,
  output logic signed [15:0] Y
);

  logic signed [16:0] x_prev_q;
  logic signed [15:0] y_prev_q;
  logic signed [19:0] y_full;

  always_comb begin
    y_full = 20'(X) - 20'(x_prev_q) + 20'(y_prev_q) - (20'(y_prev_q) >>> DC_SHIFT);
    if (y_full > 20'sd32767) begin
      Y = 16'sh7fff;
    end else if (y_full < -20'sd32768) begin
      Y = 16'sh8000;
    end else begin
      Y = 16'(y_full);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      x_prev_q <= '0;
      y_prev_q <= '0;
    end else if (EN) begin
      x_prev_q <= X;
      y_prev_q <= Y;
    end
  end

endmodule

// File: rtl/psg_stereo_mixer.sv
// Stereo panning, box-car decimation and PCM centering for TurboSound channels.
// Optional DC blocker on the output path when PSG_MIX_DCBLOCK_EN is defined.
module psg_stereo_mixer
  import psg_mix_pkg::*;
#(
  parameter int unsigned DECIM_LOG2 = 3
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  input  logic [1:0]         STEREO_MODE,
  input  logic               MUTE,
  input  logic [7:0]         CH_A,
  input  logic [7:0]         CH_B,
  input  logic [7:0]         CH_C,
  output logic signed [15:0] LEFT,
  output logic signed [15:0] RIGHT,
  output logic               VALID
);

  localparam int unsigned AW = MIX_W + DECIM_LOG2;
  localparam int unsigned CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CW-1:0] LastCnt = CW'((1 << DECIM_LOG2) - 1);

  logic [MIX_W-1:0] mix_l, mix_r;
  logic [AW-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [AW-1:0]    sum_l, sum_r;
  logic [MIX_W-1:0] avg_l, avg_r;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             win_close;

  logic signed [16:0] cen_l, cen_r;
  logic signed [15:0] out_l, out_r;
  logic signed [15:0] left_q, left_d, right_q, right_d;
  logic               valid_q, valid_d;

  always_comb begin
    unique case (STEREO_MODE)
      MONO: begin
        mix_l = {2'b0, CH_A} + {2'b0, CH_B} + {2'b0, CH_C};
        mix_r = mix_l;
      end
      ACB: begin
        mix_l = {1'b0, CH_A, 1'b0} + {2'b0, CH_C};
        mix_r = {1'b0, CH_B, 1'b0} + {2'b0, CH_C};
      end
      // Mode 11 falls back to ABC.
      default: begin
        mix_l = {1'b0, CH_A, 1'b0} + {2'b0, CH_B};
        mix_r = {1'b0, CH_C, 1'b0} + {2'b0, CH_B};
      end
    endcase
  end

  assign win_close = CE && (cnt_q == LastCnt);
  assign sum_l     = acc_l_q + AW'(mix_l);
  assign sum_r     = acc_r_q + AW'(mix_r);
  assign avg_l     = MIX_W'(sum_l >> DECIM_LOG2);
  assign avg_r     = MIX_W'(sum_r >> DECIM_LOG2);
  assign cen_l     = $signed({1'b0, avg_l, 6'b0}) - $signed(17'(CENTER_OFFSET));
  assign cen_r     = $signed({1'b0, avg_r, 6'b0}) - $signed(17'(CENTER_OFFSET));

`ifdef PSG_MIX_DCBLOCK_EN
  psg_dc_block u_dc_left (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (win_close),
    .X     (cen_l),
    .Y     (out_l)
  );

  psg_dc_block u_dc_right (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (win_close),
    .X     (cen_r),
    .Y     (out_r)
  );
`else
  assign out_l = 16'(cen_l);
  assign out_r = 16'(cen_r);
`endif

  always_comb begin
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;
    if (CE) begin
      if (win_close) begin
        acc_l_d = '0;
        acc_r_d = '0;
        cnt_d   = '0;
        valid_d = 1'b1;
        left_d  = MUTE ? 16'sd0 : out_l;
        right_d = MUTE ? 16'sd0 : out_r;
      end else begin
        acc_l_d = sum_l;
        acc_r_d = sum_r;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  end

  assign LEFT  = left_q;
  assign RIGHT = right_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Self-checking bench for psg_stereo_mixer: arithmetic reference model plus directed vectors.
module tb_psg_stereo_mixer;

  localparam int D = 3;
  localparam int N = 1 << D;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              CE = 1'b0;
  logic [1:0]        STEREO_MODE = 2'b00;
  logic              MUTE = 1'b0;
  logic [7:0]        CH_A = 8'd0;
  logic [7:0]        CH_B = 8'd0;
  logic [7:0]        CH_C = 8'd0;
  logic signed [15:0] LEFT;
  logic signed [15:0] RIGHT;
  logic              VALID;

  int checks = 0;
  int failures = 0;
  int vcount = 0;

  // Reference model state
  int m_sum_l = 0, m_sum_r = 0, m_n = 0;
  int exp_l = 0, exp_r = 0;
  bit exp_v = 1'b0;
  int xp_l = 0, yp_l = 0, xp_r = 0, yp_r = 0;

  psg_stereo_mixer #(.DECIM_LOG2(D)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .CE          (CE),
    .STEREO_MODE (STEREO_MODE),
    .MUTE        (MUTE),
    .CH_A        (CH_A),
    .CH_B        (CH_B),
    .CH_C        (CH_C),
    .LEFT        (LEFT),
    .RIGHT       (RIGHT),
    .VALID       (VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void mix_rule(input int mode, input int a, input int b, input int c,
                                   output int l, output int r);
    if (mode == 0) begin
      l = a + b + c;
      r = l;
    end else if (mode == 2) begin
      l = 2 * a + c;
      r = 2 * b + c;
    end else begin
      l = 2 * a + b;
      r = 2 * c + b;
    end
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(posedge CLK or posedge RESET) begin
    int l, r, sl, sr, xl, xr, yl, yr;
    if (RESET) begin
      m_sum_l <= 0; m_sum_r <= 0; m_n <= 0;
      exp_l <= 0; exp_r <= 0; exp_v <= 1'b0;
      xp_l <= 0; yp_l <= 0; xp_r <= 0; yp_r <= 0;
    end else begin
      exp_v <= 1'b0;
      if (CE) begin
        mix_rule(int'(STEREO_MODE), int'(CH_A), int'(CH_B), int'(CH_C), l, r);
        sl = m_sum_l + l;
        sr = m_sum_r + r;
        if (m_n + 1 == N) begin
          xl = (sl / N) * 64 - 24576;
          xr = (sr / N) * 64 - 24576;
`ifdef PSG_MIX_DCBLOCK_EN
          yl = sat16(xl - xp_l + yp_l - (yp_l >>> 8));
          yr = sat16(xr - xp_r + yp_r - (yp_r >>> 8));
          xp_l <= xl; yp_l <= yl; xp_r <= xr; yp_r <= yr;
`else
          yl = xl;
          yr = xr;
`endif
          exp_l <= MUTE ? 0 : yl;
          exp_r <= MUTE ? 0 : yr;
          exp_v <= 1'b1;
          m_sum_l <= 0; m_sum_r <= 0; m_n <= 0;
        end else begin
          m_sum_l <= sl; m_sum_r <= sr; m_n <= m_n + 1;
        end
      end
    end
  end

  // Every cycle: strobe and held outputs must match the model.
  always @(negedge CLK) begin
    chk("valid", int'(VALID), int'(exp_v));
    chk("left", int'(LEFT), exp_l);
    chk("right", int'(RIGHT), exp_r);
    if (VALID) vcount <= vcount + 1;
  end

  task automatic set_in(input logic [1:0] mode, input int a, input int b, input int c);
    STEREO_MODE = mode;
    CH_A = 8'(a);
    CH_B = 8'(b);
    CH_C = 8'(c);
  endtask

  task automatic do_ce(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      CE = 1'b1;
      @(negedge CLK);
      if (gap) begin
        CE = 1'b0;
        @(negedge CLK);
      end
    end
    CE = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge CLK);
      if (VALID) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic lit(input string name, input int l, input int r);
`ifndef PSG_MIX_DCBLOCK_EN
    chk({name, "_left"}, int'(LEFT), l);
    chk({name, "_right"}, int'(RIGHT), r);
`endif
  endtask

  initial begin
    int v0, cyc;
    repeat (3) @(negedge CLK);
    chk("rst_left", int'(LEFT), 0);
    chk("rst_right", int'(RIGHT), 0);
    chk("rst_valid", int'(VALID), 0);
    RESET = 1'b0;
    @(negedge CLK);

    set_in(2'b01, 100, 50, 0);
    do_ce(N, 1'b1);
    lit("abc", -8576, -21376);
    chk("abc_vcount", vcount, 1);

    set_in(2'b00, 255, 255, 255);
    do_ce(N, 1'b0);
    lit("mono_max", 24384, 24384);
    set_in(2'b00, 0, 0, 0);
    do_ce(N, 1'b1);
    lit("mono_zero", -24576, -24576);

    set_in(2'b10, 0, 200, 10);
    do_ce(N, 1'b0);
    lit("acb", -23936, 1664);

    // 4 samples ACB then 4 samples mode 11 (ABC) in one window.
    do_ce(N / 2, 1'b1);
    set_in(2'b11, 0, 200, 10);
    do_ce(N / 2, 1'b1);
    lit("mode_split", -17856, -4416);

    set_in(2'b01, 100, 50, 0);
    do_ce(N - 1, 1'b0);
    MUTE = 1'b1;
    v0 = vcount;
    do_ce(1, 1'b0);
    MUTE = 1'b0;
    chk("mute_left", int'(LEFT), 0);
    chk("mute_right", int'(RIGHT), 0);
    chk("mute_vcount", vcount, v0 + 1);
    do_ce(N, 1'b1);
    lit("unmute", -8576, -21376);

    do_ce(5, 1'b0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_left", int'(LEFT), 0);
    chk("midrst_right", int'(RIGHT), 0);
    v0 = vcount;
    do_ce(N - 1, 1'b1);
    chk("midrst_novalid", vcount, v0);
    do_ce(1, 1'b1);
    chk("midrst_valid", vcount, v0 + 1);
    lit("midrst_val", -8576, -21376);

    CE = 1'b1;
    wait_valid(4 * N, cyc);
    chk("cehigh_first", cyc, N);
    wait_valid(4 * N, cyc);
    chk("cehigh_period", cyc, N);
    wait_valid(4 * N, cyc);
    chk("cehigh_period2", cyc, N);
    CE = 1'b0;
    @(negedge CLK);

`ifdef PSG_MIX_DCBLOCK_EN
    set_in(2'b00, 255, 255, 255);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    CE = 1'b1;
    repeat (1200 * N) @(negedge CLK);
    CE = 1'b0;
    @(negedge CLK);
    chk("dc_decay", (LEFT < 16'sd1000 && LEFT > -16'sd1000) ? 1 : 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
